parity_frame_rx: RTL and testbench

PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

---
 rtl/parity_pkg.sv | 21 ++
 rtl/rx_bit_counter.sv | 33 +++
 rtl/parity_frame_rx.sv | 112 +++++++++++
 tb/tb_parity_frame_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame receiver.
//   state_t      : receiver FSM state encoding (IDLE, DATA, PARITY, STOP)
//   DATA_W_DEF   : default number of data bits per frame
//   cnt_width()  : bit-counter width for a given data width (never below 1)
package parity_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // A 1-bit frame still needs a 1-bit counter so the port width stays legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Data-bit counter for the frame receiver.
//   i_clk   : clock
//   i_reset : synchronous active-high reset (count -> 0)
//   i_clr   : synchronous clear (count -> 0), wins over i_en
//   i_en    : advance by one; wraps to 0 after the terminal count
//   o_count : current bit index
//   o_tc    : high while the count is at MAX-1 (last data bit)
module rx_bit_counter #(
  parameter int MAX   = 8,
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc    = (r_cnt == CNT_W'(MAX - 1));
  assign o_count = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB first, even parity,
// stop(1). The line is sampled only on cycles where bit_en is high.
//   clk, reset : clock, synchronous active-high reset
//   sin        : serial line (idle 1)
//   bit_en     : one-cycle sample strobe
//   dout       : last received data word (held until the next valid)
//   valid      : one-cycle pulse, the cycle after the stop bit is sampled
//   parity_err : even parity failed for the word on dout
//   frame_err  : stop bit sampled as 0 for the word on dout
//   busy       : frame in progress (state != IDLE)
//   dbg_state  : current FSM state, for observation only
//
// Handshake: valid is a pure pulse with no back-pressure; dout and the error
// flags are stable from the valid cycle until the next valid pulse.
import parity_pkg::*;

module parity_frame_rx #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sin,
  input  logic              bit_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int CNT_W = cnt_width(DATA_W);

  state_t             r_state;
  logic [DATA_W-1:0]  r_shift;
  logic               r_par;     // running XOR of data bits and parity bit
  logic [DATA_W-1:0]  r_dout;
  logic               r_valid;
  logic               r_perr;
  logic               r_ferr;

  logic [CNT_W-1:0]   w_cnt;
  logic               w_tc;
  logic               w_cnt_clr;
  logic               w_cnt_en;

  // Counter is cleared when a start bit is accepted and steps once per data bit.
  assign w_cnt_clr = bit_en && (r_state == ST_IDLE) && !sin;
  assign w_cnt_en  = bit_en && (r_state == ST_DATA);

  rx_bit_counter #(
    .MAX   (DATA_W),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_cnt),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bit_en) begin
        case (r_state)
          ST_IDLE: begin
            if (!sin) begin
              r_state <= ST_DATA;
              r_par   <= 1'b0;
            end
          end
          ST_DATA: begin
            r_shift[w_cnt] <= sin;
            r_par          <= r_par ^ sin;
            if (w_tc) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_par   <= r_par ^ sin;
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            // Deliver the frame even when flagged; errors ride along with it.
            r_dout  <= r_shift;
            r_perr  <= r_par;
            r_ferr  <= !sin;
            r_valid <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign valid      = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_parity_frame_rx.sv
module tb_parity_frame_rx;
  import parity_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         sin;
  logic         bit_en;
  logic [W-1:0] dout;
  logic         valid;
  logic         parity_err;
  logic         frame_err;
  logic         busy;
  state_t       dbg_state;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .bit_en     (bit_en),
    .dout       (dout),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  logic [W+1:0] exp_q[$];   // {frame_err, parity_err, dout}
  int           vcyc_q[$];  // cycle stamps of observed valid pulses
  logic         prev_valid = 1'b0;
  logic [W-1:0] last_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame's outcome follows directly from the bits sent.
  task automatic expect_frame(input logic [W-1:0] data, input logic par, input logic stop);
    logic perr;
    perr = (^data) ^ par;
    exp_q.push_back({~stop, perr, data});
    last_data = data;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (valid) begin
      check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
      vcyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("frame", {22'd0, frame_err, parity_err, dout}, {22'd0, e});
      end
    end
    prev_valid <= valid;
  end

  // ---------------- driver tasks (entered at a negedge) ----------------
  function automatic int pick_gap(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
  endfunction

  task automatic strobe(input logic b, input int gap);
    sin    = b;
    bit_en = 1'b1;
    @(negedge clk);
    if (gap > 0) begin
      bit_en = 1'b0;
      for (int k = 0; k < gap; k++) begin
        sin = 1'($urandom_range(0, 1));  // line is ignored without bit_en
        @(negedge clk);
      end
    end
  endtask

  task automatic idle();
    bit_en = 1'b0;
    sin    = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_body(input logic [W-1:0] data, input logic par, input logic stop,
                           input int maxgap);
    for (int i = 0; i < W; i++) strobe(data[i], pick_gap(maxgap));
    strobe(par, pick_gap(maxgap));
    strobe(stop, pick_gap(maxgap));
  endtask

  task automatic send_frame(input logic [W-1:0] data, input logic par, input logic stop,
                            input int maxgap);
    expect_frame(data, par, stop);
    strobe(1'b0, pick_gap(maxgap));
    send_body(data, par, stop, maxgap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b1;
    sin    = 1'b1;
    bit_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout",  {24'd0, dout}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_perr",  {31'd0, parity_err}, 32'd0);
    check("rst_ferr",  {31'd0, frame_err}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    reset = 1'b0;

    // Clean frame, strobe every cycle
    send_frame(8'hA8, 1'b1, 1'b1, 0);
    idle();
    drain();

    // Parity error, then a good frame
    send_frame(8'hA8, 1'b0, 1'b1, 0);
    send_frame(8'hA9, 1'b0, 1'b1, 0);
    idle();
    drain();

    // Framing error, FSM returns to IDLE
    send_frame(8'hA9, 1'b0, 1'b0, 0);
    idle();
    check("ferr_state_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("ferr_busy", {31'd0, busy}, 32'd0);
    drain();

    // Reset mid-frame (after 4 data bits); reset also overrides a start bit
    strobe(1'b0, 0);
    for (int i = 0; i < 4; i++) strobe(1'($urandom_range(0, 1)), 0);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    sin    = 1'b0;
    bit_en = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    bit_en = 1'b0;
    sin    = 1'b1;
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_dout",  {24'd0, dout}, 32'd0);
    repeat (4) @(negedge clk);
    send_frame(8'hAB, 1'b1, 1'b1, 0);
    idle();
    drain();

    // Sparse idle strobes, then a frame with gapped strobes
    for (int i = 0; i < 10; i++) begin
      strobe(1'b1, int'($urandom_range(2, 6)));
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("hold_dout", {24'd0, dout}, {24'd0, last_data});
    end
    expect_frame(8'hAD, 1'b1, 1'b1);
    strobe(1'b0, int'($urandom_range(2, 6)));
    check("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < W; i++) strobe(last_data[i], int'($urandom_range(2, 6)));
    strobe(1'b1, int'($urandom_range(2, 6)));
    strobe(1'b1, int'($urandom_range(2, 6)));
    idle();
    drain();

    // Back-to-back frames: valid pulses exactly one frame (11 strobes) apart
    vcyc_q.delete();
    send_frame(8'hA8, 1'b1, 1'b1, 0);
    send_frame(8'hB0, 1'b1, 1'b1, 0);
    idle();
    drain();
    check("b2b_pulses", vcyc_q.size(), 32'd2);
    if (vcyc_q.size() == 2) check("b2b_spacing", vcyc_q[1] - vcyc_q[0], 32'd11);

    // Random frames: random data, parity bit, stop bit, and strobe gaps
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      send_frame(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 3);
      if ($urandom_range(0, 2) == 0) strobe(1'b1, pick_gap(3));
    end
    idle();
    drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
